// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - time-division arbiter sharing one single-port RAM between video fetch and CPU
module vram_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int SLOT_CNT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sync,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  output logic              vid_miss,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SW = $clog2(SLOT_CNT);
  localparam logic [SW-1:0] CPU_SLOT = SW'(SLOT_CNT - 1);

  typedef enum logic [1:0] {OWN_IDLE, OWN_VID, OWN_CPU} owner_e;

  logic [SW-1:0] slot;
  logic          cpu_busy;
  logic          cpu_ok;
  logic          wr2;
  owner_e        owner, own1, own2;

  // Reserved slot favours the CPU; every other slot favours video.
  always_comb begin
    cpu_ok = cpu_req && !cpu_busy;
    owner  = OWN_IDLE;
    if (slot == CPU_SLOT) begin
      if (cpu_ok)       owner = OWN_CPU;
      else if (vid_req) owner = OWN_VID;
    end else begin
      if (vid_req)      owner = OWN_VID;
      else if (cpu_ok)  owner = OWN_CPU;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot      <= '0;
      cpu_busy  <= 1'b0;
      own1      <= OWN_IDLE;
      own2      <= OWN_IDLE;
      wr2       <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      vid_data  <= '0;
      vid_valid <= 1'b0;
      vid_miss  <= 1'b0;
      cpu_rdata <= '0;
      cpu_ack   <= 1'b0;
    end else begin
      if (sync || slot == CPU_SLOT) slot <= '0;
      else                          slot <= slot + SW'(1);

      mem_en    <= (owner != OWN_IDLE);
      mem_we    <= (owner == OWN_CPU) && cpu_we;
      mem_addr  <= (owner == OWN_CPU) ? cpu_addr : vid_addr;
      mem_wdata <= cpu_wdata;
      vid_miss  <= vid_req && (owner != OWN_VID);

      own1 <= owner;
      own2 <= own1;
      wr2  <= mem_we;

      // RAM data for the access issued two edges ago is on mem_rdata now.
      vid_valid <= (own2 == OWN_VID);
      cpu_ack   <= (own2 == OWN_CPU);
      if (own2 == OWN_VID) vid_data <= mem_rdata;
      if (own2 == OWN_CPU && !wr2) cpu_rdata <= mem_rdata;

      if (owner == OWN_CPU)     cpu_busy <= 1'b1;
      else if (own2 == OWN_CPU) cpu_busy <= 1'b0;
    end
  end

endmodule
